// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue stage.
//   alu_op_e     - 4-bit ALU opcode seen by the downstream ALU
//   OPC_*        - RV32I major opcodes decoded by this stage
//   F7_*         - funct7 values that select the alternate (SUB/SRA) forms
//   alu_ctrl_t   - complete operand/control vector handed to the ALU
//   funct3_to_op - shared funct3 -> opcode map used by OP and OP-IMM
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        nx;
        logic        ix;
        logic        sx;
        logic        ny;
        logic        iy;
        logic        sy;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic        illegal;
    } alu_ctrl_t;

    // Shared by OP and OP-IMM; 'alt' only matters for funct3=101 (SRL vs SRA).
    function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000: op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_decode: purely combinational RV32I decoder for OP, OP-IMM and LUI.
//   instr    in  32  raw instruction word
//   rs1_data in  32  rs1 register value
//   rs2_data in  32  rs2 register value
//   ctrl     out     decoded alu_ctrl_t (illegal forms zero the operands/controls)
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_ctrl_t   ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a bit unassigned, which is what would otherwise infer a latch.
        ctrl        = '0;
        ctrl.x      = rs1_data;
        ctrl.y      = rs2_data;
        ctrl.rd     = instr[11:7];
        ctrl.alu_op = ALU_ADD;
        bad         = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    ctrl.alu_op = funct3_to_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    // SUB is ADD with y inverted and incremented (two's complement).
                    ctrl.ny = 1'b1;
                    ctrl.iy = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl.alu_op = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: 5-bit shamt, upper bits act as funct7.
                    ctrl.y = {27'b0, instr[24:20]};
                    if (funct7 == F7_BASE) begin
                        ctrl.alu_op = funct3_to_op(funct3, 1'b0);
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        ctrl.alu_op = ALU_SRA;
                    end else begin
                        bad = 1'b1;
                    end
                end else begin
                    // Raw 12-bit immediate; the ALU sign-extends it via sy.
                    ctrl.y      = {20'b0, instr[31:20]};
                    ctrl.sy     = 1'b1;
                    ctrl.alu_op = funct3_to_op(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                ctrl.x = 32'b0;
                ctrl.y = {instr[31:12], 12'b0};
            end
            default: bad = 1'b1;
        endcase

        // Illegal instructions still flow through, but as a harmless 0+0.
        if (bad) begin
            ctrl.x       = 32'b0;
            ctrl.y       = 32'b0;
            ctrl.nx      = 1'b0;
            ctrl.ix      = 1'b0;
            ctrl.sx      = 1'b0;
            ctrl.ny      = 1'b0;
            ctrl.iy      = 1'b0;
            ctrl.sy      = 1'b0;
            ctrl.alu_op  = ALU_ADD;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the ALU with a
// 2-entry skid buffer (main = head entry, skid = second entry).
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake (in_ready from state only)
//   instr, rs1_data, rs2_data  instruction and operands
//   out_valid/out_ready        downstream handshake
//   x, y, nx..sy, alu_op, rd   decoded ALU vector (head entry)
//   illegal                    head entry was not a supported instruction
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        nx,
    output logic        ix,
    output logic        sx,
    output logic        ny,
    output logic        iy,
    output logic        sy,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        illegal
);

    alu_ctrl_t dec;
    alu_ctrl_t main_q, main_d;
    alu_ctrl_t skid_q, skid_d;
    logic      main_valid_q, main_valid_d;
    logic      skid_valid_q, skid_valid_d;
    logic      accept;
    logic      drain;

    alu_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .ctrl     (dec)
    );

    // The skid slot is the only thing that can block upstream.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (drain) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no accept competes with the refill.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    // NOTE: the data registers are reset too, not just the valid bits, because
    // the outputs must read as all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign x         = main_q.x;
    assign y         = main_q.y;
    assign nx        = main_q.nx;
    assign ix        = main_q.ix;
    assign sx        = main_q.sx;
    assign ny        = main_q.ny;
    assign iy        = main_q.iy;
    assign sy        = main_q.sy;
    assign alu_op    = main_q.alu_op;
    assign rd        = main_q.rd;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-to-back
// throughput, skid-buffer stall/release ordering and mid-flight reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        nx, ix, sx, ny, iy, sy;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .nx        (nx),
        .ix        (ix),
        .sx        (sx),
        .ny        (ny),
        .iy        (iy),
        .sy        (sy),
        .alu_op    (alu_op),
        .rd        (rd),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Controls packed as {nx,ix,sx,ny,iy,sy}.
    function automatic logic [31:0] ctrls();
        return {26'b0, nx, ix, sx, ny, iy, sy};
    endfunction

    // Check the full output vector of the head entry.
    task automatic check_vec(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                             input logic [5:0] ectl, input logic [3:0] eop,
                             input logic [4:0] erd, input logic eill);
        check({tag, ".valid"},   {31'b0, out_valid}, 32'd1);
        check({tag, ".x"},       x, ex);
        check({tag, ".y"},       y, ey);
        check({tag, ".ctrl"},    ctrls(), {26'b0, ectl});
        check({tag, ".alu_op"},  {28'b0, alu_op}, {28'b0, eop});
        check({tag, ".rd"},      {27'b0, rd}, {27'b0, erd});
        check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, eill});
    endtask

    // Present one instruction and advance one clock; in_valid stays high so
    // consecutive calls stream at one per cycle. Sampling is #1 after the edge.
    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'b0;
        rs1_data  = 32'b0;
        rs2_data  = 32'b0;
        out_ready = 1'b1;

        // ---- reset state
        #12;
        check("rst.in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.x",         x, 32'd0);
        check("rst.y",         y, 32'd0);
        check("rst.ctrl",      ctrls(), 32'd0);
        check("rst.alu_op",    {28'b0, alu_op}, 32'd0);
        check("rst.rd",        {27'b0, rd}, 32'd0);
        check("rst.illegal",   {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- decode vectors streamed back to back (out_ready=1)
        send(32'h002081B3, 32'd5, 32'd7);            // add x3,x1,x2
        check_vec("add", 32'd5, 32'd7, 6'b000000, 4'd0, 5'd3, 1'b0);
        send(32'h402081B3, 32'd5, 32'd7);            // sub x3,x1,x2
        check_vec("sub", 32'd5, 32'd7, 6'b000110, 4'd0, 5'd3, 1'b0);
        send(32'hFFF00093, 32'd9, 32'd1);            // addi x1,x0,-1
        check_vec("addi", 32'd9, 32'h00000FFF, 6'b000001, 4'd0, 5'd1, 1'b0);
        send(32'h4040D193, 32'h80000000, 32'd1);     // srai x3,x1,4
        check_vec("srai", 32'h80000000, 32'd4, 6'b000000, 4'd6, 5'd3, 1'b0);
        send(32'h123452B7, 32'd11, 32'd22);          // lui x5,0x12345
        check_vec("lui", 32'd0, 32'h12345000, 6'b000000, 4'd0, 5'd5, 1'b0);
        send(32'h00000000, 32'd11, 32'd22);          // unknown opcode
        check_vec("op0", 32'd0, 32'd0, 6'b000000, 4'd0, 5'd0, 1'b1);
        send(32'h0020C1B3, 32'd3, 32'd6);            // xor x3,x1,x2
        check_vec("xor", 32'd3, 32'd6, 6'b000000, 4'd3, 5'd3, 1'b0);
        send(32'h4020D1B3, 32'd3, 32'd6);            // sra x3,x1,x2
        check_vec("sra", 32'd3, 32'd6, 6'b000000, 4'd6, 5'd3, 1'b0);
        send(32'h8000F193, 32'd3, 32'd6);            // andi x3,x1,-2048
        check_vec("andi", 32'd3, 32'h00000800, 6'b000001, 4'd1, 5'd3, 1'b0);
        send(32'h022081B3, 32'd3, 32'd6);            // mul: funct7 not supported
        check_vec("mul", 32'd0, 32'd0, 6'b000000, 4'd0, 5'd3, 1'b1);
        send(32'h4020C1B3, 32'd3, 32'd6);            // funct7=0100000 with funct3=100
        check_vec("altxor", 32'd0, 32'd0, 6'b000000, 4'd0, 5'd3, 1'b1);
        send(32'h40109093, 32'd3, 32'd6);            // slli with funct7=0100000
        check_vec("badslli", 32'd0, 32'd0, 6'b000000, 4'd0, 5'd1, 1'b1);
        check("stream.in_ready", {31'b0, in_ready}, 32'd1);
        idle_cycle();
        check("drain.out_valid", {31'b0, out_valid}, 32'd0);

        // ---- skid buffer: stall, fill, release in order
        out_ready = 1'b0;
        send(32'h002081B3, 32'hA, 32'd0);            // A -> main
        check("skid.A.x", x, 32'hA);
        check("skid.A.in_ready", {31'b0, in_ready}, 32'd1);
        send(32'h002081B3, 32'hB, 32'd0);            // B -> skid
        check("skid.B.in_ready", {31'b0, in_ready}, 32'd0);
        check("skid.B.hold_x", x, 32'hA);
        send(32'h002081B3, 32'hC, 32'd0);            // C refused
        check("skid.C.in_ready", {31'b0, in_ready}, 32'd0);
        check("skid.C.hold_x", x, 32'hA);
        check("skid.C.valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        send(32'h002081B3, 32'hC, 32'd0);            // A leaves, B moves up
        check("rel.B.x", x, 32'hB);
        check("rel.B.valid", {31'b0, out_valid}, 32'd1);
        check("rel.B.in_ready", {31'b0, in_ready}, 32'd1);
        send(32'h002081B3, 32'hC, 32'd0);            // B leaves, C accepted
        check("rel.C.x", x, 32'hC);
        check("rel.C.valid", {31'b0, out_valid}, 32'd1);
        idle_cycle();
        check("rel.empty", {31'b0, out_valid}, 32'd0);

        // ---- reset with both entries full
        out_ready = 1'b0;
        send(32'h002081B3, 32'h1, 32'd0);
        send(32'h002081B3, 32'h2, 32'd0);
        check("fill.in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mrst.out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst.in_ready",  {31'b0, in_ready}, 32'd1);
        check("mrst.x",         x, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post.out_valid", {31'b0, out_valid}, 32'd0);
        send(32'h0020C1B3, 32'h77, 32'h88);
        check_vec("post.xor", 32'h77, 32'h88, 6'b000000, 4'd3, 5'd3, 1'b0);
        idle_cycle();
        check("post.empty", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
